// File: rtl/trigger_interval_meter.sv
// ---------------------------------------------------------------------------
// trigger_interval_meter
//   Samples a trigger line, detects rising edges and measures the number of
//   clock cycles between successive edges. Each measured interval is reported
//   with a one-cycle valid strobe. A match strobe accompanies intervals equal
//   to EXPECT. A sticky timeout flags a gap longer than MAX_INTERVAL cycles.
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   trigger    in   monitored line (level or pulse), synchronous to clk
//   clear      in   synchronous soft clear; returns everything to IDLE/zero
//   interval   out  [WIDTH-1:0] last measured rising-edge spacing
//   valid      out  one-cycle strobe: interval just updated
//   match      out  one-cycle strobe: valid and interval == EXPECT
//   timeout    out  sticky: no edge within MAX_INTERVAL cycles
//   busy       out  state machine is in COUNT
//   edge_count out  [7:0] saturating count of detected rising edges
// ---------------------------------------------------------------------------
module trigger_interval_meter #(
    parameter int WIDTH        = 8,
    parameter int MAX_INTERVAL = 255,
    parameter int EXPECT       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             clear,
    output logic [WIDTH-1:0] interval,
    output logic             valid,
    output logic             match,
    output logic             timeout,
    output logic             busy,
    output logic [7:0]       edge_count
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_INTERVAL);
    localparam logic [WIDTH-1:0] EXP_W = WIDTH'(EXPECT);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] interval_q, interval_d;
    logic             valid_q, valid_d;
    logic             match_q, match_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic [7:0]       ec_q, ec_d;

    logic edge_det;
    assign edge_det = trigger & ~prev_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        interval_d = interval_q;
        valid_d    = 1'b0;
        match_d    = 1'b0;
        timeout_d  = timeout_q;
        ec_d       = ec_q;

        if (clear) begin
            // An edge coincident with clear is deliberately dropped.
            state_d    = S_IDLE;
            cnt_d      = '0;
            interval_d = '0;
            timeout_d  = 1'b0;
            ec_d       = '0;
        end else begin
            if (edge_det && (ec_q != 8'hFF)) begin
                ec_d = ec_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (edge_det) begin
                        cnt_d   = ONE_W;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    // An edge on the cycle cnt == MAX is still a measurement,
                    // so the edge test comes before the limit test.
                    if (edge_det) begin
                        interval_d = cnt_q;
                        valid_d    = 1'b1;
                        match_d    = (cnt_q == EXP_W);
                        cnt_d      = ONE_W;
                    end else if (cnt_q == MAX_W) begin
                        timeout_d = 1'b1;
                        state_d   = S_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + ONE_W;
                    end
                end
                S_TIMEOUT: begin
                    // Interval across a timeout is unmeasurable: restart only.
                    if (edge_det) begin
                        cnt_d   = ONE_W;
                        state_d = S_COUNT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            interval_q <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            ec_q       <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= trigger;  // updates during clear too
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            ec_q       <= ec_d;
        end
    end

    assign interval   = interval_q;
    assign valid      = valid_q;
    assign match      = match_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;
    assign edge_count = ec_q;

endmodule

// File: doc/trigger_interval_meter.md
Name: trigger_interval_meter

Overview:
- Receive-side companion to the countdown trigger generators: samples a trigger line and measures the clock-cycle spacing between successive rising edges.
- Reports each measured interval with a one-cycle valid strobe, flags intervals equal to an expected value, and flags a missing trigger with a sticky timeout.
- Sits on the consumer side of any trigger/pulse source in lab designs. Doubles as a bench monitor for trigger generators.

Parameters:
- WIDTH, 8, width of the interval counter and the interval output.
- MAX_INTERVAL, 255, largest measurable interval; must be ≤ 2**WIDTH-1 and ≥ 2.
- EXPECT, 4, interval value that asserts match.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- trigger  input  1  monitored line; level or pulse, synchronous to clk.
- clear  input  1  synchronous soft clear.
- interval  output  WIDTH  last measured rising-edge spacing, in cycles.
- valid  output  1  one-cycle strobe: interval was just updated.
- match  output  1  one-cycle strobe: valid is high and interval == EXPECT.
- timeout  output  1  sticky: no edge arrived within MAX_INTERVAL cycles.
- busy  output  1  high when the state machine is in COUNT.
- edge_count  output  8  saturating count of detected rising edges.

Behaviour:
- Reset: asynchronous and active-high. It forces the following immediately, with no clock edge needed:
  - state = IDLE
  - prev = 0, cnt = 0
  - interval = 0, valid = 0, match = 0, timeout = 0, busy = 0, edge_count = 0
- Reset mid-measurement discards the measurement in progress.
- Edge detect:
  - prev <= trigger on every posedge, including during clear.
  - edge = trigger & ~prev.
  - A level held high produces exactly one edge.
  - The minimum possible edge spacing is 2 cycles.
- All outputs are registered. valid and match rise one clock after the posedge that samples the edge.
- States:
  - IDLE: cnt holds. On edge: cnt <= 1, go to COUNT.
  - COUNT (busy = 1):
    - On edge: interval <= cnt, valid <= 1, match <= (cnt == EXPECT), cnt <= 1, stay in COUNT.
    - No edge and cnt == MAX_INTERVAL: timeout <= 1, cnt holds, go to TIMEOUT.
    - Otherwise: cnt <= cnt + 1.
  - TIMEOUT:
    - On edge: cnt <= 1, go to COUNT. valid is not asserted, because that interval is unmeasurable.
    - timeout remains 1 in TIMEOUT and COUNT until cleared.
- Interval definition: edges sampled at posedges t0 and t1 give interval = t1 - t0. Range is 2..MAX_INTERVAL.
- An edge in the same cycle that cnt == MAX_INTERVAL is a valid measurement of MAX_INTERVAL, not a timeout.
- valid and match are low in every cycle except the one after a measured edge. interval holds its value between measurements.
- edge_count increments on every detected edge in any state and saturates at 255 (no wrap).
- clear:
  - Priority is below rst and above all other events.
  - Next state is IDLE. cnt, interval, valid, match, timeout, busy and edge_count all go to 0.
  - An edge sampled in the same cycle as clear is ignored: not counted, starts no measurement. prev still updates, so a level that stays high does not re-trigger afterwards.
- No arithmetic overflow is possible: cnt never exceeds MAX_INTERVAL.

Test Plan:
- Reset: assert rst with trigger = 0 and hold for 2 cycles. All outputs = 0. Assert rst asynchronously mid-COUNT: outputs clear before the next posedge.
- Periodic pulse: trigger high for 1 cycle every 4 cycles, 3 pulses.
  - After pulse 2: valid = 1 for exactly 1 cycle, interval = 4, match = 1.
  - After pulse 3: same result, edge_count = 3, busy = 1 throughout.
- Held level (countdown style), with MAX_INTERVAL = 10: trigger rises and stays high.
  - edge_count = 1, valid never asserts.
  - timeout = 1 exactly 10 cycles after the edge sample, and stays 1.
- Minimum and non-matching spacing: edges 2 cycles apart give interval = 2, match = 0. Then edges 7 apart give interval = 7, match = 0.
- Recovery from timeout, with MAX_INTERVAL = 10: after timeout, an edge arrives with no valid. A next edge 5 cycles later gives interval = 5, valid = 1, timeout still 1.
- Clear: pulse clear mid-COUNT, coincident with an edge.
  - Next cycle: IDLE, edge_count = 0, timeout = 0, interval = 0.
  - The following edge gives no valid; the second edge after it gives a correct interval.
